// File: rtl/led_blink_timer.sv
// led_blink_timer: 1 ms prescaler plus a ms counter that toggles the LED
// every interval_ms milliseconds. interval_ms == 0 parks the block in IDLE
// with the LED off.
//
// Optional build macro BLINK_RESTART_ON_WRITE_EN: when defined, the block
// keeps a registered copy of interval_ms. A nonzero change while running
// restarts the prescaler and the ms counter, so the next toggle lands exactly
// interval_ms(new) ms after the write. When undefined, a new interval takes
// effect at the next tick without disturbing the LED phase or the prescaler.
//
// state | meaning
// IDLE  | interval_ms == 0; LED off, prescaler and ms counter held at 0
// RUN   | prescaler free-running; LED toggles every interval_ms ticks

module led_blink_timer #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int INTERVAL_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INTERVAL_W-1:0] interval_ms,
   output logic                  led,
   output logic                  tick_ms,
   output logic                  toggle
);

   localparam int CYCLES_PER_MS = CLK_FREQ_HZ / 1000;
   localparam int PRE_W         = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CYCLES_PER_MS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [INTERVAL_W-1:0] ms_q, ms_d;
   logic                  led_q, led_d;
   logic                  tick_q, tick_d;
   logic                  tog_q, tog_d;
   logic [INTERVAL_W-1:0] ms_last;
   logic                  pre_wrap;
   logic                  restart;

`ifdef BLINK_RESTART_ON_WRITE_EN
   logic [INTERVAL_W-1:0] interval_q, interval_d;

   // Restart only for a nonzero change; a change to 0 takes the IDLE path.
   always_comb begin
      interval_d = interval_ms;
      restart    = (interval_ms != interval_q);
   end
`else
   // Without the restart feature a new interval simply applies at the next tick.
   always_comb begin
      restart = 1'b0;
   end
`endif

   // Terminal ms count; only formed for a nonzero interval so it cannot underflow.
   always_comb begin
      ms_last  = (interval_ms != '0) ? (interval_ms - INTERVAL_W'(1)) : '0;
      pre_wrap = (pre_q == PRE_LAST);
   end

   // Next-state and output logic; strobes default low every cycle.
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      ms_d    = ms_q;
      led_d   = led_q;
      tick_d  = 1'b0;
      tog_d   = 1'b0;
      case (state_q)
         IDLE: begin
            pre_d = '0;
            ms_d  = '0;
            led_d = 1'b0;
            if (interval_ms != '0) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (interval_ms == '0) begin
               // Going idle beats a toggle due in the same cycle.
               state_d = IDLE;
               pre_d   = '0;
               ms_d    = '0;
               led_d   = 1'b0;
            end else if (restart) begin
               pre_d = '0;
               ms_d  = '0;
            end else if (pre_wrap) begin
               pre_d  = '0;
               tick_d = 1'b1;
               if (ms_q >= ms_last) begin
                  ms_d  = '0;
                  led_d = ~led_q;
                  tog_d = 1'b1;
               end else begin
                  ms_d = ms_q + INTERVAL_W'(1);
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            pre_d   = '0;
            ms_d    = '0;
            led_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pre_q   <= '0;
         ms_q    <= '0;
         led_q   <= 1'b0;
         tick_q  <= 1'b0;
         tog_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         ms_q    <= ms_d;
         led_q   <= led_d;
         tick_q  <= tick_d;
         tog_q   <= tog_d;
      end
   end

`ifdef BLINK_RESTART_ON_WRITE_EN
   // Copy of the last interval value, used to detect writes while running.
   always_ff @(posedge clk) begin
      if (rst) begin
         interval_q <= '0;
      end else begin
         interval_q <= interval_d;
      end
   end
`endif

   assign led     = led_q;
   assign tick_ms = tick_q;
   assign toggle  = tog_q;

endmodule

// File: tb/tb_led_blink_timer.sv
// Directed bench for led_blink_timer (default build, restart-on-write off).
// Main instance: CLK_FREQ_HZ=10_000 -> 10 cycles per ms.
// Second instance: 8-bit interval, 2 cycles per ms, to exercise the
// all-ones interval within a short run.

module tb_led_blink_timer;

   logic        clk;
   logic        rst;
   logic [15:0] interval_ms;
   logic        led;
   logic        tick_ms;
   logic        toggle;

   logic        rst2;
   logic [7:0]  interval2;
   logic        led2;
   logic        tick2;
   logic        toggle2;

   int errors;
   int checks;

   typedef struct {
      logic        rst;
      logic [15:0] iv;
      int          adv;
      logic        led;
      logic        tick;
      logic        tog;
   } vec_t;

   vec_t vecs[29];

   led_blink_timer #(.CLK_FREQ_HZ(10_000), .INTERVAL_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .interval_ms (interval_ms),
      .led         (led),
      .tick_ms     (tick_ms),
      .toggle      (toggle)
   );

   led_blink_timer #(.CLK_FREQ_HZ(2_000), .INTERVAL_W(8)) u_max (
      .clk         (clk),
      .rst         (rst2),
      .interval_ms (interval2),
      .led         (led2),
      .tick_ms     (tick2),
      .toggle      (toggle2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int n_led, n_tick, n_tog;
      int t2, g2;
      errors = 0;
      checks = 0;

      // Directed table continuing from IDLE after the reset test.
      vecs[0]  = '{1'b0, 16'd3, 10, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 16'd3,  1, 1'b0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 16'd3,  1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 16'd3, 19, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{1'b0, 16'd3,  1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 16'd3, 28, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 16'd3,  1, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 16'd3, 30, 1'b1, 1'b1, 1'b1};
      vecs[8]  = '{1'b0, 16'd5, 40, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 16'd2,  9, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 16'd2,  1, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 16'd2, 10, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 16'd2, 10, 1'b1, 1'b1, 1'b1};
      vecs[13] = '{1'b0, 16'd2, 10, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 16'd4, 10, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 16'd4, 20, 1'b0, 1'b1, 1'b1};
      vecs[16] = '{1'b0, 16'd1, 10, 1'b1, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 16'd1,  9, 1'b1, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 16'd0,  1, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 16'd0,  5, 1'b0, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 16'd1,  1, 1'b0, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 16'd1,  9, 1'b0, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 16'd1,  1, 1'b1, 1'b1, 1'b1};
      vecs[23] = '{1'b0, 16'd3, 10, 1'b1, 1'b1, 1'b0};
      vecs[24] = '{1'b0, 16'd3,  4, 1'b1, 1'b0, 1'b0};
      vecs[25] = '{1'b1, 16'd3,  1, 1'b0, 1'b0, 1'b0};
      vecs[26] = '{1'b0, 16'd3,  1, 1'b0, 1'b0, 1'b0};
      vecs[27] = '{1'b0, 16'd3, 29, 1'b0, 1'b0, 1'b0};
      vecs[28] = '{1'b0, 16'd3,  1, 1'b1, 1'b1, 1'b1};

      // Reset with interval 0, then 100 idle cycles.
      rst         = 1'b1;
      interval_ms = '0;
      rst2        = 1'b1;
      interval2   = '0;
      step(2);
      chk("reset_led",    int'(led),     0);
      chk("reset_tick",   int'(tick_ms), 0);
      chk("reset_toggle", int'(toggle),  0);
      rst  = 1'b0;
      rst2 = 1'b0;
      n_led = 0; n_tick = 0; n_tog = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (led)     n_led++;
         if (tick_ms) n_tick++;
         if (toggle)  n_tog++;
      end
      chk("idle_led_high_cycles",    n_led,  0);
      chk("idle_tick_high_cycles",   n_tick, 0);
      chk("idle_toggle_high_cycles", n_tog,  0);

      for (int v = 0; v < 29; v++) begin
         rst         = vecs[v].rst;
         interval_ms = vecs[v].iv;
         step(vecs[v].adv);
         chk($sformatf("vec%0d_led", v),    int'(led),     int'(vecs[v].led));
         chk($sformatf("vec%0d_tick", v),   int'(tick_ms), int'(vecs[v].tick));
         chk($sformatf("vec%0d_toggle", v), int'(toggle),  int'(vecs[v].tog));
      end
      rst = 1'b0;

      // All-ones interval on the 8-bit instance: 255 ms half-period, 2 cycles/ms.
      interval2 = 8'hFF;
      t2 = 0;
      g2 = 0;
      for (int i = 1; i <= 1021; i++) begin
         step(1);
         if (tick2)   t2++;
         if (toggle2) g2++;
         if (i == 510) begin
            chk("max_led_before_first", int'(led2), 0);
            chk("max_toggles_before_first", g2, 0);
         end
         if (i == 511) begin
            chk("max_led_first_rise", int'(led2), 1);
            chk("max_toggle_first", int'(toggle2), 1);
            chk("max_ticks_to_first", t2, 255);
         end
         if (i == 1020) begin
            chk("max_led_before_second", int'(led2), 1);
         end
         if (i == 1021) begin
            chk("max_led_second_fall", int'(led2), 0);
            chk("max_toggle_second", int'(toggle2), 1);
            chk("max_toggle_count", g2, 2);
            chk("max_ticks_to_second", t2, 510);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_blink_timer.md
Name: led_blink_timer

Overview:
- Timing core directly downstream of the MMIO interval register. Consumes the registered 16-bit interval_ms value and drives the LED.
- Generates a free-running 1 ms tick from the system clock and counts ms ticks. Toggles the LED every interval_ms milliseconds.
- Exports tick and toggle strobes for status and debug.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency; CYCLES_PER_MS = CLK_FREQ_HZ/1000, must be >= 2
INTERVAL_W, 16, width of interval_ms and of the ms counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
interval_ms  input  INTERVAL_W  LED half-period in ms, from the MMIO register; 0 = blinking disabled
led  output  1  LED drive, registered
tick_ms  output  1  one-cycle strobe, once per ms
toggle  output  1  one-cycle strobe, asserted in the cycle led changes value

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: led=0, tick_ms=0, toggle=0, prescaler=0, ms_cnt=0, state=IDLE, interval_q=0.
- Prescaler:
  - Counts 0..CYCLES_PER_MS-1 and wraps to 0.
  - tick_ms is registered and high for exactly one cycle after prescaler reaches CYCLES_PER_MS-1. Spacing between ticks is exactly CYCLES_PER_MS cycles.
  - Cleared and held at 0 in IDLE.
- State machine:
  - IDLE: interval_ms==0. led forced 0, ms_cnt=0, prescaler=0, tick_ms=0, toggle=0.
    - Moves to RUN in the cycle after interval_ms becomes nonzero. Counting starts from prescaler=0, ms_cnt=0.
  - RUN: on each tick_ms:
    - If ms_cnt >= interval_ms-1: ms_cnt<=0, led<=~led, toggle<=1.
    - Otherwise ms_cnt<=ms_cnt+1.
    - Moves to IDLE in the cycle after interval_ms==0 is sampled.
- Timing: first toggle (led 0->1) occurs interval_ms*CYCLES_PER_MS cycles after RUN entry. Full LED period is 2*interval_ms ms.
- Arithmetic:
  - Comparison uses >=, unsigned, INTERVAL_W bits.
  - interval_ms-1 is computed only when interval_ms != 0; no underflow path.
  - interval_ms=0xFFFF is legal. ms_cnt never exceeds 0xFFFE.
- Interval change in RUN (default, macro absent):
  - The new value is used from the next tick.
  - Shrinking below the current ms_cnt gives a toggle on the next tick.
  - Growing extends the current half-period.
  - led phase and prescaler are undisturbed.
- Simultaneous events:
  - interval_ms going to 0 in the same cycle a tick would toggle: IDLE wins, no toggle, led=0 next cycle.
  - rst has priority over everything.
- Reset mid-operation: all state returns to reset values in the next cycle, regardless of led or count.
- interval_ms is assumed stable between writes (it comes from a register). It is not synchronised internally.

Optional Feature:
- Macro: BLINK_RESTART_ON_WRITE_EN.
- Defined:
  - Block keeps interval_q, a registered copy of interval_ms.
  - When interval_ms != interval_q in RUN with interval_ms != 0: prescaler<=0 and ms_cnt<=0 in that cycle, led holds its value, no toggle.
  - The next toggle is exactly interval_ms(new)*CYCLES_PER_MS cycles later.
  - The change-to-0 case still goes to IDLE.
- Undefined: interval_q is not instantiated. The new interval applies as described under Behaviour.

Test Plan (CLK_FREQ_HZ=10_000, so CYCLES_PER_MS=10):
1. Reset, interval_ms=0 for 100 cycles -> led=0, tick_ms and toggle never asserted.
2. interval_ms=3 from IDLE -> tick_ms every 10 cycles; led rises 30 cycles after RUN entry, then toggles every 30 cycles; toggle coincides with each led edge.
3. interval_ms=5 running, ms_cnt=4, change to 2 -> led toggles on the next tick (default build). With BLINK_RESTART_ON_WRITE_EN -> no toggle until 20 cycles after the change.
4. interval_ms=1 running, set to 0 in the same cycle as a toggle-due tick -> no toggle strobe, led=0 next cycle; restore to 1 -> first toggle 10 cycles after RUN entry.
5. interval_ms=0xFFFF -> ms_cnt reaches 0xFFFE and wraps, led toggles at tick 65535, no overflow.
6. Assert rst with led=1 and ms_cnt mid-count -> led=0, counters 0, state IDLE next cycle; with interval_ms held, first toggle interval_ms*10 cycles after the IDLE->RUN transition.
